// File: rtl/adc_sampler.sv
// adc_sampler: periodic XADC conversion controller. Issues start-of-conversion
// pulses, guards each conversion with a watchdog, and averages 2^AVG_LOG2 results.
module adc_sampler #(
    parameter int unsigned SAMPLE_DIV = 100000,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned AVG_LOG2   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        clear_err,
    output logic        AdcSoc,
    input  logic        AdcEoc,
    input  logic [11:0] AdcData,
    output logic [11:0] sample_data,
    output logic        sample_valid,
    output logic        busy,
    output logic        timeout_err,
    output logic        overrun_err
);
    localparam int unsigned PER_W = $clog2(SAMPLE_DIV);
    localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned ACC_W = 12 + AVG_LOG2;

    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_DIV - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_EOC
    } state_t;

    state_t           state;
    logic [PER_W-1:0] per_cnt;
    logic [WD_W-1:0]  wd;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic             tick;

    assign tick = enable && (per_cnt == PER_LAST);
    assign sum  = acc + ACC_W'(AdcData);

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            per_cnt <= '0;
        end else if (per_cnt == PER_LAST) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + PER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wd           <= '0;
            cnt          <= '0;
            acc          <= '0;
            AdcSoc       <= 1'b0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            AdcSoc       <= 1'b0;
            sample_valid <= 1'b0;

            // Later assignments win, so a new error overrides clear_err in the same cycle.
            if (clear_err) begin
                timeout_err <= 1'b0;
                overrun_err <= 1'b0;
            end
            if (tick && state != IDLE) begin
                overrun_err <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    acc  <= '0;
                    cnt  <= '0;
                    busy <= 1'b0;
                    if (tick) begin
                        state  <= START;
                        AdcSoc <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                START: begin
                    wd    <= '0;
                    state <= WAIT_EOC;
                end
                WAIT_EOC: begin
                    wd <= wd + WD_W'(1);
                    // EOC is tested first so it wins over a watchdog expiring in the same cycle.
                    if (AdcEoc) begin
                        if (cnt == CNT_LAST) begin
                            sample_data  <= sum[ACC_W-1 -: 12];
                            sample_valid <= 1'b1;
                            busy         <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            acc    <= sum;
                            cnt    <= cnt + CNT_W'(1);
                            AdcSoc <= 1'b1;
                            state  <= START;
                        end
                    end else if (wd == WD_LAST) begin
                        timeout_err <= 1'b1;
                        acc         <= '0;
                        cnt         <= '0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sampler.sv
// Bench for adc_sampler: behavioural XADC model, scoreboard of expected averages,
// and directed checks on timing, watchdog, overrun, reset and enable behaviour.
module tb_adc_sampler;
    localparam int SAMPLE_DIV = 100;
    localparam int TIMEOUT    = 64;
    localparam int AVG_LOG2   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        clear_err = 1'b0;
    logic        AdcSoc;
    logic        AdcEoc = 1'b0;
    logic [11:0] AdcData = '0;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic        busy;
    logic        timeout_err;
    logic        overrun_err;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 20;
    int          spur_req_n = 0;
    int          data_q[$];
    logic [11:0] exp_q[$];
    int          soc_q[$];

    adc_sampler #(
        .SAMPLE_DIV(SAMPLE_DIV),
        .TIMEOUT   (TIMEOUT),
        .AVG_LOG2  (AVG_LOG2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .clear_err   (clear_err),
        .AdcSoc      (AdcSoc),
        .AdcEoc      (AdcEoc),
        .AdcData     (AdcData),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .busy        (busy),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endfunction

    // XADC model: EOC arrives 'lat' cycles after the Soc cycle; a -1 entry withholds EOC.
    initial begin : xadc_model
        int countdown;
        int spur_seen;
        int v;
        countdown = 0;
        spur_seen = 0;
        forever begin
            @(negedge clk);
            AdcEoc = 1'b0;
            if (spur_req_n != spur_seen) begin
                spur_seen = spur_req_n;
                AdcEoc    = 1'b1;
                AdcData   = 12'hABC;
            end
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0 && data_q.size() > 0) begin
                    v = data_q.pop_front();
                    if (v >= 0) begin
                        AdcEoc  = 1'b1;
                        AdcData = 12'(v);
                    end
                end
            end
            if (!rst && AdcSoc === 1'b1) countdown = lat;
        end
    end

    initial begin : monitor
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (AdcSoc === 1'b1) soc_q.push_back(cyc);
            if (sample_valid === 1'b1) begin
                check("valid_single_cycle", int'(prev_valid), 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got sample_valid with data 0x%0h, expected no sample", sample_data);
                end else begin
                    check("sample_data", int'(sample_data), int'(exp_q.pop_front()));
                end
            end
            prev_valid = sample_valid;
        end
    end

    task automatic wait_socs(input int n, input int bound, input string name);
        int seen;
        int t;
        seen = 0;
        t = 0;
        while (seen < n && t < bound) begin
            @(negedge clk);
            t++;
            if (AdcSoc === 1'b1) seen++;
        end
        if (seen < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got %0d AdcSoc pulses, expected %0d within %0d cycles", name, seen, n, bound);
        end
    endtask

    task automatic wait_valid(input int bound, input string name);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (sample_valid !== 1'b1 && t < bound);
        if (sample_valid !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no sample_valid, expected one within %0d cycles", name, bound);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_soc"}, int'(AdcSoc), 0);
        check({tag, "_data"}, int'(sample_data), 0);
        check({tag, "_valid"}, int'(sample_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_timeout_err"}, int'(timeout_err), 0);
        check({tag, "_overrun_err"}, int'(overrun_err), 0);
    endtask

    initial begin : stimulus
        int c_en;
        int s1;
        int t;
        int base;
        int n1;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Bursts: plain average, full scale, truncation.
        data_q.push_back(12'h100); data_q.push_back(12'h102);
        data_q.push_back(12'h104); data_q.push_back(12'h106);
        repeat (4) data_q.push_back(4095);
        data_q.push_back(1); data_q.push_back(1); data_q.push_back(1); data_q.push_back(0);
        exp_q.push_back(12'h103);
        exp_q.push_back(12'hFFF);
        exp_q.push_back(12'h000);
        @(negedge clk);
        enable = 1'b1;
        c_en = cyc;
        wait_valid(300, "burst1_valid");
        check("burst1_busy_at_valid", int'(busy), 0);
        wait_valid(200, "burst2_valid");
        wait_valid(200, "burst3_valid");
        check("soc_count_3_bursts", soc_q.size(), 12);
        if (soc_q.size() >= 12) begin
            check("first_soc_latency", soc_q[0] - c_en, SAMPLE_DIV);
            check("soc_spacing_1_2", soc_q[1] - soc_q[0], 21);
            check("soc_spacing_3_4", soc_q[3] - soc_q[2], 21);
            check("burst_period_1_2", soc_q[4] - soc_q[0], SAMPLE_DIV);
            check("burst_period_2_3", soc_q[8] - soc_q[4], SAMPLE_DIV);
        end

        // Withheld EOC on the second conversion.
        data_q.push_back(12'h200);
        data_q.push_back(-1);
        wait_socs(2, 200, "timeout_socs");
        s1 = cyc;
        t = 0;
        while (timeout_err !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("timeout_latency", cyc - s1, TIMEOUT + 1);
        check("timeout_busy", int'(busy), 0);
        data_q.push_back(12'h010); data_q.push_back(12'h020);
        data_q.push_back(12'h030); data_q.push_back(12'h040);
        exp_q.push_back(12'h028);
        wait_valid(200, "after_timeout_valid");
        check("timeout_err_sticky", int'(timeout_err), 1);
        check("no_overrun_yet", int'(overrun_err), 0);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("timeout_err_cleared", int'(timeout_err), 0);

        // Slow model: burst outlasts the sample period.
        lat = 40;
        base = soc_q.size();
        data_q.push_back(12'h300); data_q.push_back(12'h310);
        data_q.push_back(12'h320); data_q.push_back(12'h330);
        data_q.push_back(7); data_q.push_back(8); data_q.push_back(9); data_q.push_back(10);
        exp_q.push_back(12'h318);
        exp_q.push_back(12'h008);
        wait_valid(300, "overrun_valid1");
        wait_valid(300, "overrun_valid2");
        enable = 1'b0;
        check("overrun_err_set", int'(overrun_err), 1);
        check("overrun_soc_count", soc_q.size() - base, 8);
        if (soc_q.size() >= base + 8) begin
            check("overrun_burst_period", soc_q[base + 4] - soc_q[base], 2 * SAMPLE_DIV);
        end

        // Reset in the middle of a conversion.
        lat = 20;
        data_q.push_back(12'h050);
        data_q.push_back(12'h060);
        enable = 1'b1;
        wait_socs(2, 300, "rst_socs");
        repeat (9) @(negedge clk);
        check("busy_in_wait_eoc", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        data_q.push_back(12'h400); data_q.push_back(12'h401);
        data_q.push_back(12'h402); data_q.push_back(12'h403);
        exp_q.push_back(12'h401);
        wait_valid(300, "post_rst_valid");

        // enable dropped during the third conversion.
        data_q.push_back(12'h011); data_q.push_back(12'h022);
        data_q.push_back(12'h033); data_q.push_back(12'h044);
        exp_q.push_back(12'h02A);
        wait_socs(3, 300, "disable_socs");
        repeat (5) @(negedge clk);
        enable = 1'b0;
        wait_valid(200, "disable_valid");
        check("disable_busy_at_valid", int'(busy), 0);
        n1 = soc_q.size();
        repeat (250) @(negedge clk);
        check("no_soc_while_disabled", soc_q.size(), n1);
        spur_req_n++;
        repeat (5) @(negedge clk);
        check("spurious_busy", int'(busy), 0);
        check("spurious_data_held", int'(sample_data), 12'h02A);
        check("spurious_no_soc", soc_q.size(), n1);
        check("spurious_no_timeout", int'(timeout_err), 0);
        check("all_samples_seen", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
